// File: rtl/mem_access_unit_if.sv
// Bundle of EXE-side, write-back-side and data-memory signals of the MEM stage.
// The slave modport is the MEM stage itself; the master modport is its environment.
interface mem_access_unit_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RfAddrWidth  = 5,
  parameter int unsigned GprCtrlWidth = 3,
  parameter int unsigned MemCtrlWidth = 4
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                    exe_valid_i;
  logic                    exe_ready_o;
  logic [DataWidth-1:0]    exe_out_i;
  logic [DataWidth-1:0]    store_data_i;
  logic [DataWidth-1:0]    op3_i;
  logic [RfAddrWidth-1:0]  rd_i;
  logic [GprCtrlWidth-1:0] gpr_ctrl_i;
  logic [MemCtrlWidth-1:0] mem_ctrl_i;

  logic                    wb_valid_o;
  logic [DataWidth-1:0]    exe_out_o;
  logic [DataWidth-1:0]    op3_o;
  logic [RfAddrWidth-1:0]  rd_o;
  logic [GprCtrlWidth-1:0] gpr_ctrl_o;
  logic [MemCtrlWidth-1:0] mem_ctrl_o;
  logic [DataWidth-1:0]    d_m_rdata_o;
  logic                    misaligned_o;

  logic                    d_m_req_o;
  logic                    d_m_gnt_i;
  logic [DataWidth-1:0]    d_m_addr_o;
  logic                    d_m_we_o;
  logic [BeWidth-1:0]      d_m_be_o;
  logic [DataWidth-1:0]    d_m_wdata_o;
  logic                    d_m_rvalid_i;
  logic [DataWidth-1:0]    d_m_rdata_i;

  modport slave (
    input  exe_valid_i, exe_out_i, store_data_i, op3_i, rd_i, gpr_ctrl_i, mem_ctrl_i,
    input  d_m_gnt_i, d_m_rvalid_i, d_m_rdata_i,
    output exe_ready_o, wb_valid_o, exe_out_o, op3_o, rd_o, gpr_ctrl_o, mem_ctrl_o,
    output d_m_rdata_o, misaligned_o,
    output d_m_req_o, d_m_addr_o, d_m_we_o, d_m_be_o, d_m_wdata_o
  );

  modport master (
    output exe_valid_i, exe_out_i, store_data_i, op3_i, rd_i, gpr_ctrl_i, mem_ctrl_i,
    output d_m_gnt_i, d_m_rvalid_i, d_m_rdata_i,
    input  exe_ready_o, wb_valid_o, exe_out_o, op3_o, rd_o, gpr_ctrl_o, mem_ctrl_o,
    input  d_m_rdata_o, misaligned_o,
    input  d_m_req_o, d_m_addr_o, d_m_we_o, d_m_be_o, d_m_wdata_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: passes non-memory ops through and runs one req/gnt/rvalid data-memory
// transaction per LOAD/STORE, handing registered results to write-back.
package core_pkg;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned ADDR_OFFSET_WIDTH = 2;
  localparam int unsigned RF_ADDR_WIDTH     = 5;
  localparam int unsigned GPR_CTRL_WIDTH    = 3;
  localparam int unsigned MEM_CTRL_WIDTH    = 4;

  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_IDLE = 4'd0;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RB   = 4'd1;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RBU  = 4'd2;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RH   = 4'd3;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RHU  = 4'd4;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RW   = 4'd5;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RWU  = 4'd6;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RD   = 4'd7;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WB   = 4'd8;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WH   = 4'd9;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WW   = 4'd10;
  localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WD   = 4'd11;
endpackage

module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = core_pkg::DATA_WIDTH,
  parameter int unsigned OFF_WIDTH  = core_pkg::ADDR_OFFSET_WIDTH
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_access_unit_if.slave bus
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q;
  logic [OFF_WIDTH-1:0]  off;
  logic                  is_mem;
  logic                  is_store;
  logic [1:0]            size;
  logic                  misaligned;
  logic [BE_WIDTH-1:0]   be_base;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] addr_aligned;

  assign bus.exe_ready_o = (state_q == StIdle) && !rst_i;

  // size: 0=byte, 1=half, 2=word, 3=full bus width
  always_comb begin
    off      = bus.exe_out_i[OFF_WIDTH-1:0];
    is_mem   = 1'b1;
    is_store = 1'b0;
    size     = 2'd0;
    case (bus.mem_ctrl_i)
      core_pkg::MEM_RB, core_pkg::MEM_RBU: size = 2'd0;
      core_pkg::MEM_RH, core_pkg::MEM_RHU: size = 2'd1;
      core_pkg::MEM_RW, core_pkg::MEM_RWU: size = 2'd2;
      core_pkg::MEM_RD:                    size = 2'd3;
      core_pkg::MEM_WB: begin is_store = 1'b1; size = 2'd0; end
      core_pkg::MEM_WH: begin is_store = 1'b1; size = 2'd1; end
      core_pkg::MEM_WW: begin is_store = 1'b1; size = 2'd2; end
      core_pkg::MEM_WD: begin is_store = 1'b1; size = 2'd3; end
      core_pkg::MEM_IDLE: is_mem = 1'b0;
      default:            is_mem = 1'b0;
    endcase

    case (size)
      2'd1:    misaligned = is_mem && off[0];
      2'd2:    misaligned = is_mem && (off[1:0] != 2'b00);
      2'd3:    misaligned = is_mem && (off != '0);
      default: misaligned = 1'b0;
    endcase

    case (size)
      2'd0:    be_base = BE_WIDTH'(1);
      2'd1:    be_base = BE_WIDTH'(3);
      2'd2:    be_base = BE_WIDTH'(15);
      default: be_base = '1;
    endcase

    be           = is_store ? (be_base << off) : '1;
    wdata        = bus.store_data_i << {off, 3'b000};
    addr_aligned = {bus.exe_out_i[DATA_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      bus.wb_valid_o   <= 1'b0;
      bus.exe_out_o    <= '0;
      bus.op3_o        <= '0;
      bus.rd_o         <= '0;
      bus.gpr_ctrl_o   <= '0;
      bus.mem_ctrl_o   <= '0;
      bus.d_m_rdata_o  <= '0;
      bus.misaligned_o <= 1'b0;
      bus.d_m_req_o    <= 1'b0;
      bus.d_m_addr_o   <= '0;
      bus.d_m_we_o     <= 1'b0;
      bus.d_m_be_o     <= '0;
      bus.d_m_wdata_o  <= '0;
    end else begin
      bus.wb_valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.exe_valid_i) begin
            bus.exe_out_o    <= bus.exe_out_i;
            bus.op3_o        <= bus.op3_i;
            bus.gpr_ctrl_o   <= bus.gpr_ctrl_i;
            bus.mem_ctrl_o   <= bus.mem_ctrl_i;
            bus.misaligned_o <= misaligned;
            bus.d_m_rdata_o  <= '0;
            // Misaligned ops retire as a write to x0 so write-back stays harmless
            bus.rd_o         <= misaligned ? '0 : bus.rd_i;
            if (!is_mem || misaligned) begin
              bus.wb_valid_o <= 1'b1;
            end else begin
              state_q         <= StReq;
              bus.d_m_req_o   <= 1'b1;
              bus.d_m_addr_o  <= addr_aligned;
              bus.d_m_we_o    <= is_store;
              bus.d_m_be_o    <= be;
              bus.d_m_wdata_o <= wdata;
            end
          end
        end
        StReq: begin
          if (bus.d_m_gnt_i) begin
            state_q       <= StWait;
            bus.d_m_req_o <= 1'b0;
          end
        end
        StWait: begin
          if (bus.d_m_rvalid_i) begin
            state_q         <= StIdle;
            bus.wb_valid_o  <= 1'b1;
            bus.d_m_rdata_o <= bus.d_m_we_o ? '0 : bus.d_m_rdata_i;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, pass-through, load, store, misaligned,
// reset abort and stall scenarios with hand-computed expectations.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DataWidth(32)) bus ();

  mem_access_unit #(.DATA_WIDTH(32), .OFF_WIDTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  localparam logic [2:0] GprAlu = 3'd1;
  localparam logic [2:0] GprMem = 3'd2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exe_valid_i  = 1'b0;
    bus.exe_out_i    = '0;
    bus.store_data_i = '0;
    bus.op3_i        = '0;
    bus.rd_i         = '0;
    bus.gpr_ctrl_i   = '0;
    bus.mem_ctrl_i   = core_pkg::MEM_IDLE;
    bus.d_m_gnt_i    = 1'b0;
    bus.d_m_rvalid_i = 1'b0;
    bus.d_m_rdata_i  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.exe_ready_o !== 1'b0) begin bad++;
      $display("FAIL reset_ready got=%b want=0", bus.exe_ready_o); end
    total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL reset_wb_valid got=%b want=0", bus.wb_valid_o); end
    total++; if (bus.d_m_req_o !== 1'b0) begin bad++;
      $display("FAIL reset_req got=%b want=0", bus.d_m_req_o); end
    total++; if (bus.exe_out_o !== 32'h0 || bus.misaligned_o !== 1'b0) begin bad++;
      $display("FAIL reset_outs got=%h/%b want=0/0", bus.exe_out_o, bus.misaligned_o); end
    rst = 1'b0;
    #1;
    total++; if (bus.exe_ready_o !== 1'b1) begin bad++;
      $display("FAIL post_reset_ready got=%b want=1", bus.exe_ready_o); end
  endtask

  task automatic test_pass_through();
    int pulses = 0;
    bus.exe_valid_i = 1'b1;
    bus.gpr_ctrl_i  = GprAlu;
    bus.mem_ctrl_i  = core_pkg::MEM_IDLE;
    bus.exe_out_i   = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) bus.exe_valid_i = 1'b0;
      if (bus.wb_valid_o === 1'b1) pulses++;
      total++; if (bus.exe_out_o !== 32'h1234) begin bad++;
        $display("FAIL pt_exe_out[%0d] got=%h want=1234", i, bus.exe_out_o); end
      total++; if (bus.d_m_req_o !== 1'b0) begin bad++;
        $display("FAIL pt_req[%0d] got=%b want=0", i, bus.d_m_req_o); end
    end
    total++; if (pulses != 3) begin bad++;
      $display("FAIL pt_pulses got=%0d want=3", pulses); end
    tick();
    total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL pt_wb_drop got=%b want=0", bus.wb_valid_o); end
  endtask

  task automatic test_load();
    bus.exe_valid_i = 1'b1;
    bus.mem_ctrl_i  = core_pkg::MEM_RB;
    bus.gpr_ctrl_i  = GprMem;
    bus.exe_out_i   = 32'h1003;
    bus.rd_i        = 5'd5;
    tick();  // T1
    bus.exe_valid_i = 1'b0;
    total++; if (bus.d_m_req_o !== 1'b1 || bus.d_m_addr_o !== 32'h1000) begin bad++;
      $display("FAIL ld_req got=%b/%h want=1/00001000", bus.d_m_req_o, bus.d_m_addr_o); end
    total++; if (bus.d_m_be_o !== 4'hF || bus.d_m_we_o !== 1'b0) begin bad++;
      $display("FAIL ld_be_we got=%h/%b want=f/0", bus.d_m_be_o, bus.d_m_we_o); end
    bus.d_m_gnt_i = 1'b1;
    tick();  // T2
    bus.d_m_gnt_i    = 1'b0;
    bus.d_m_rvalid_i = 1'b1;
    bus.d_m_rdata_i  = 32'hAABBCCDD;
    total++; if (bus.d_m_req_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL ld_t2 got=%b/%b want=0/0", bus.d_m_req_o, bus.wb_valid_o); end
    tick();  // T3
    bus.d_m_rvalid_i = 1'b0;
    total++; if (bus.wb_valid_o !== 1'b1 || bus.d_m_rdata_o !== 32'hAABBCCDD) begin bad++;
      $display("FAIL ld_wb got=%b/%h want=1/aabbccdd", bus.wb_valid_o, bus.d_m_rdata_o); end
    total++; if (bus.exe_out_o !== 32'h1003 || bus.rd_o !== 5'd5) begin bad++;
      $display("FAIL ld_fields got=%h/%0d want=1003/5", bus.exe_out_o, bus.rd_o); end
    total++; if (bus.exe_ready_o !== 1'b1) begin bad++;
      $display("FAIL ld_ready_t3 got=%b want=1", bus.exe_ready_o); end
    tick();
    total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL ld_pulse got=%b want=0", bus.wb_valid_o); end
  endtask

  task automatic test_store();
    bus.exe_valid_i  = 1'b1;
    bus.mem_ctrl_i   = core_pkg::MEM_WH;
    bus.exe_out_i    = 32'h2002;
    bus.store_data_i = 32'h0000BEEF;
    tick();
    bus.exe_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.d_m_req_o !== 1'b1 || bus.d_m_addr_o !== 32'h2000 ||
                   bus.d_m_we_o !== 1'b1) begin bad++;
        $display("FAIL st_req[%0d] got=%b/%h/%b want=1/00002000/1", i, bus.d_m_req_o,
                 bus.d_m_addr_o, bus.d_m_we_o); end
      total++; if (bus.d_m_be_o !== 4'hC || bus.d_m_wdata_o !== 32'hBEEF0000) begin bad++;
        $display("FAIL st_be_wdata[%0d] got=%h/%h want=c/beef0000", i, bus.d_m_be_o,
                 bus.d_m_wdata_o); end
      if (i == 3) bus.d_m_gnt_i = 1'b1;
      tick();
    end
    bus.d_m_gnt_i    = 1'b0;
    bus.d_m_rvalid_i = 1'b1;
    bus.d_m_rdata_i  = 32'h12345678;
    total++; if (bus.d_m_req_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL st_wait got=%b/%b want=0/0", bus.d_m_req_o, bus.wb_valid_o); end
    tick();
    bus.d_m_rvalid_i = 1'b0;
    total++; if (bus.wb_valid_o !== 1'b1 || bus.d_m_rdata_o !== 32'h0) begin bad++;
      $display("FAIL st_wb got=%b/%h want=1/0", bus.wb_valid_o, bus.d_m_rdata_o); end
    total++; if (bus.mem_ctrl_o !== core_pkg::MEM_WH) begin bad++;
      $display("FAIL st_mem_ctrl got=%0d want=%0d", bus.mem_ctrl_o, core_pkg::MEM_WH); end
  endtask

  task automatic test_misaligned();
    bus.exe_valid_i = 1'b1;
    bus.mem_ctrl_i  = core_pkg::MEM_RW;
    bus.exe_out_i   = 32'h3001;
    bus.rd_i        = 5'd7;
    tick();
    bus.exe_valid_i = 1'b0;
    total++; if (bus.d_m_req_o !== 1'b0 || bus.wb_valid_o !== 1'b1) begin bad++;
      $display("FAIL mis_req_wb got=%b/%b want=0/1", bus.d_m_req_o, bus.wb_valid_o); end
    total++; if (bus.misaligned_o !== 1'b1 || bus.rd_o !== 5'd0) begin bad++;
      $display("FAIL mis_flag_rd got=%b/%0d want=1/0", bus.misaligned_o, bus.rd_o); end
    tick();
    total++; if (bus.d_m_req_o !== 1'b0 || bus.wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL mis_after got=%b/%b want=0/0", bus.d_m_req_o, bus.wb_valid_o); end
  endtask

  task automatic test_reset_abort();
    bus.exe_valid_i = 1'b1;
    bus.mem_ctrl_i  = core_pkg::MEM_RW;
    bus.exe_out_i   = 32'h4000;
    bus.rd_i        = 5'd4;
    tick();
    bus.exe_valid_i = 1'b0;
    bus.d_m_gnt_i   = 1'b1;
    tick();  // now waiting for rvalid
    bus.d_m_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (bus.d_m_req_o !== 1'b0 || bus.exe_ready_o !== 1'b0) begin bad++;
      $display("FAIL abort_in_rst got=%b/%b want=0/0", bus.d_m_req_o, bus.exe_ready_o); end
    rst = 1'b0;
    bus.d_m_rvalid_i = 1'b1;
    bus.d_m_rdata_i  = 32'hDEADBEEF;
    #1;
    total++; if (bus.exe_ready_o !== 1'b1) begin bad++;
      $display("FAIL abort_ready got=%b want=1", bus.exe_ready_o); end
    tick();
    bus.d_m_rvalid_i = 1'b0;
    total++; if (bus.wb_valid_o !== 1'b0 || bus.d_m_rdata_o !== 32'h0) begin bad++;
      $display("FAIL abort_stale got=%b/%h want=0/0", bus.wb_valid_o, bus.d_m_rdata_o); end
    total++; if (bus.exe_ready_o !== 1'b1 || bus.d_m_req_o !== 1'b0) begin bad++;
      $display("FAIL abort_idle got=%b/%b want=1/0", bus.exe_ready_o, bus.d_m_req_o); end
  endtask

  task automatic test_stall();
    bus.exe_valid_i = 1'b1;
    bus.mem_ctrl_i  = core_pkg::MEM_RW;
    bus.gpr_ctrl_i  = GprMem;
    bus.exe_out_i   = 32'h5000;
    bus.op3_i       = 32'h11;
    bus.rd_i        = 5'd3;
    tick();  // T1: second instruction presented and held
    bus.mem_ctrl_i = core_pkg::MEM_IDLE;
    bus.gpr_ctrl_i = GprAlu;
    bus.exe_out_i  = 32'h12345678;
    bus.op3_i      = 32'h22;
    bus.rd_i       = 5'd9;
    for (int t = 1; t <= 4; t++) begin
      total++; if (bus.exe_ready_o !== 1'b0 || bus.exe_out_o !== 32'h5000) begin bad++;
        $display("FAIL stall_hold[%0d] got=%b/%h want=0/00005000", t, bus.exe_ready_o,
                 bus.exe_out_o); end
      bus.d_m_gnt_i    = (t == 2);
      bus.d_m_rvalid_i = (t == 4);
      bus.d_m_rdata_i  = (t == 4) ? 32'hCAFEF00D : 32'h0;
      tick();
    end
    bus.d_m_rvalid_i = 1'b0;
    total++; if (bus.wb_valid_o !== 1'b1 || bus.d_m_rdata_o !== 32'hCAFEF00D) begin bad++;
      $display("FAIL stall_wb got=%b/%h want=1/cafef00d", bus.wb_valid_o, bus.d_m_rdata_o); end
    total++; if (bus.rd_o !== 5'd3 || bus.op3_o !== 32'h11 || bus.exe_ready_o !== 1'b1) begin
      bad++; $display("FAIL stall_fields got=%0d/%h/%b want=3/11/1", bus.rd_o, bus.op3_o,
                      bus.exe_ready_o); end
    tick();
    bus.exe_valid_i = 1'b0;
    total++; if (bus.wb_valid_o !== 1'b1 || bus.exe_out_o !== 32'h12345678 ||
                 bus.rd_o !== 5'd9) begin bad++;
      $display("FAIL stall_next got=%b/%h/%0d want=1/12345678/9", bus.wb_valid_o,
               bus.exe_out_o, bus.rd_o); end
    total++; if (bus.d_m_req_o !== 1'b0 || bus.misaligned_o !== 1'b0) begin bad++;
      $display("FAIL stall_next_bus got=%b/%b want=0/0", bus.d_m_req_o, bus.misaligned_o); end
    tick();
    total++; if (bus.wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL stall_end got=%b want=0", bus.wb_valid_o); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_pass_through();
    test_load();
    test_store();
    test_misaligned();
    test_reset_abort();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
